// File: rtl/rgb_pwm_gen_if.sv
// Duty-triple handshake between the SoC and the RGB PWM generator.
interface rgb_pwm_gen_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] duty_r;
    logic [WIDTH-1:0] duty_g;
    logic [WIDTH-1:0] duty_b;
    logic             duty_valid;
    logic             duty_ready;

    modport master (
        output duty_r, duty_g, duty_b, duty_valid,
        input  duty_ready
    );

    modport slave (
        input  duty_r, duty_g, duty_b, duty_valid,
        output duty_ready
    );
endinterface

// File: rtl/rgb_pwm_gen.sv
// Three-channel PWM generator for the RGB LED driver; new duty values are
// buffered and only take effect at a period boundary.
module rgb_pwm_gen #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    rgb_pwm_gen_if.slave          duty_if,
    output logic                  red_pwm,
    output logic                  green_pwm,
    output logic                  blue_pwm,
    output logic                  period_tick
);

    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [WIDTH-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]      active_r_q, active_g_q, active_b_q;
    logic [WIDTH-1:0]      active_r_d, active_g_d, active_b_d;
    logic [WIDTH-1:0]      pending_r_q, pending_g_q, pending_b_q;
    logic [WIDTH-1:0]      pending_r_d, pending_g_d, pending_b_d;
    logic                  pend_full_q, pend_full_d;
    logic                  tick_q, tick_d;
    logic [2:0]            pwm_q, pwm_d;

    logic step;
    logic boundary;
    logic accept;
    logic apply;

    // While disabled the counters sit at zero and any pending triple is
    // applied immediately, so the next enable starts a clean period.
    always_comb begin
        step        = en && (pre_cnt_q >= prescale);
        boundary    = step && (cnt_q == {WIDTH{1'b1}});
        accept      = duty_if.duty_valid && !pend_full_q;
        apply       = pend_full_q && (boundary || !en);

        pre_cnt_d   = pre_cnt_q;
        cnt_d       = cnt_q;
        active_r_d  = active_r_q;
        active_g_d  = active_g_q;
        active_b_d  = active_b_q;
        pending_r_d = pending_r_q;
        pending_g_d = pending_g_q;
        pending_b_d = pending_b_q;
        pend_full_d = pend_full_q;

        if (!en) begin
            pre_cnt_d = '0;
            cnt_d     = '0;
        end else if (step) begin
            pre_cnt_d = '0;
            cnt_d     = cnt_q + 1'b1;
        end else begin
            pre_cnt_d = pre_cnt_q + 1'b1;
        end

        if (apply) begin
            active_r_d  = pending_r_q;
            active_g_d  = pending_g_q;
            active_b_d  = pending_b_q;
            pend_full_d = 1'b0;
        end

        if (accept) begin
            pending_r_d = duty_if.duty_r;
            pending_g_d = duty_if.duty_g;
            pending_b_d = duty_if.duty_b;
            pend_full_d = 1'b1;
        end

        tick_d = boundary;
        pwm_d  = {en && (cnt_q < active_b_q),
                  en && (cnt_q < active_g_q),
                  en && (cnt_q < active_r_q)};
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pre_cnt_q   <= '0;
            cnt_q       <= '0;
            active_r_q  <= '0;
            active_g_q  <= '0;
            active_b_q  <= '0;
            pending_r_q <= '0;
            pending_g_q <= '0;
            pending_b_q <= '0;
            pend_full_q <= 1'b0;
            tick_q      <= 1'b0;
            pwm_q       <= '0;
        end else begin
            pre_cnt_q   <= pre_cnt_d;
            cnt_q       <= cnt_d;
            active_r_q  <= active_r_d;
            active_g_q  <= active_g_d;
            active_b_q  <= active_b_d;
            pending_r_q <= pending_r_d;
            pending_g_q <= pending_g_d;
            pending_b_q <= pending_b_d;
            pend_full_q <= pend_full_d;
            tick_q      <= tick_d;
            pwm_q       <= pwm_d;
        end
    end

    assign duty_if.duty_ready = !pend_full_q;
    assign red_pwm            = pwm_q[0];
    assign green_pwm          = pwm_q[1];
    assign blue_pwm           = pwm_q[2];
    assign period_tick        = tick_q;

endmodule
